hash_match: RTL and testbench

HASH_MATCH -- requirements
Module: hash_match

---
 rtl/hash_match.sv | 102 ++++++++++
 tb/tb_hash_match.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hash_match.sv
// MD5 digest finalisation and target compare behind the 64-op hash chain.
// Optional `HASH_COUNT_EN adds a saturating count of candidates checked while searching.
module hash_match #(
   parameter logic [31:0] A0 = 32'h67452301,
   parameter logic [31:0] B0 = 32'hefcdab89,
   parameter logic [31:0] C0 = 32'h98badcfe,
   parameter logic [31:0] D0 = 32'h10325476
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [31:0]  a_in,
   input  logic [31:0]  b_in,
   input  logic [31:0]  c_in,
   input  logic [31:0]  d_in,
   input  logic [151:0] m_in,
   input  logic         valid_in,
   input  logic [127:0] target_hash,
   input  logic         start,
   input  logic         ack,
   output logic         match_found,
   output logic [151:0] match_msg,
   output logic         searching
`ifdef HASH_COUNT_EN
   ,
   output logic [31:0]  hash_count
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEARCH = 2'd1;
   localparam logic [1:0] FOUND  = 2'd2;

   logic [1:0]   state;
   logic [127:0] target_reg;
   logic [31:0]  a1, b1, c1, d1;
   logic [151:0] m1, m2;
   logic         valid1, valid2, hit;
   logic         take_hit, accept_start;

   // MD5 words are little-endian; the digest byte stream is each word byte-swapped.
   function automatic logic [31:0] swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         a1 <= '0; b1 <= '0; c1 <= '0; d1 <= '0;
         m1 <= '0; valid1 <= 1'b0;
         m2 <= '0; valid2 <= 1'b0; hit <= 1'b0;
      end else if (en) begin
         a1     <= a_in + A0;
         b1     <= b_in + B0;
         c1     <= c_in + C0;
         d1     <= d_in + D0;
         m1     <= m_in;
         valid1 <= valid_in;
         hit    <= valid1 && ({swap32(a1), swap32(b1), swap32(c1), swap32(d1)} == target_reg);
         m2     <= m1;
         valid2 <= valid1;
      end
   end

   // A stalled pipeline must not act on a stale hit; a hit beats a concurrent start.
   assign take_hit     = (state == SEARCH) && en && hit;
   assign accept_start = start && ((state == IDLE) || ((state == SEARCH) && !take_hit));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         target_reg <= '0;
         match_msg  <= '0;
      end else begin
         if (accept_start)
            target_reg <= target_hash;
         case (state)
            IDLE:    if (start) state <= SEARCH;
            SEARCH:  if (take_hit) begin
                        state     <= FOUND;
                        match_msg <= m2;
                     end
            FOUND:   if (ack) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign match_found = (state == FOUND);
   assign searching   = (state == SEARCH);

`ifdef HASH_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         hash_count <= '0;
      else if (accept_start)
         hash_count <= '0;
      else if ((state == SEARCH) && en && valid2 && (hash_count != 32'hFFFFFFFF))
         hash_count <= hash_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_hash_match.sv
// Directed bench for hash_match: scoreboard of expected match messages, immediate-assert checks.
module tb_hash_match;

   logic         clk = 1'b0;
   logic         reset, en, valid_in, start, ack;
   logic [31:0]  a_in, b_in, c_in, d_in;
   logic [151:0] m_in;
   logic [127:0] target_hash;
   logic         match_found, searching;
   logic [151:0] match_msg;
`ifdef HASH_COUNT_EN
   logic [31:0]  hash_count;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [151:0] exp_q[$];
   logic [151:0] exp_msg;

   // Zero state words plus the default MD5 IV produce exactly this digest.
   localparam logic [127:0] T_ZERO  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] T_OTHER = {128{1'b1}};

   hash_match dut (
      .clk(clk), .reset(reset), .en(en),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
      .m_in(m_in), .valid_in(valid_in), .target_hash(target_hash),
      .start(start), .ack(ack),
      .match_found(match_found), .match_msg(match_msg), .searching(searching)
`ifdef HASH_COUNT_EN
      , .hash_count(hash_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [151:0] obs, input logic [151:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [151:0] m, input logic v, input logic hit_expected);
      a_in = a; b_in = '0; c_in = '0; d_in = '0;
      m_in = m; valid_in = v;
      if (hit_expected) exp_q.push_back(m);
   endtask

   task automatic idle_inputs();
      valid_in = 1'b0; m_in = '0; a_in = 32'hdead_beef;
   endtask

   task automatic pop_check(input string tag);
      if (exp_q.size() == 0) begin
         vectors++; miscompares++;
         $error("FAIL %s: observed empty scoreboard expected one entry", tag);
      end else begin
         exp_msg = exp_q.pop_front();
         check(tag, match_msg, exp_msg);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; start = 1'b0; ack = 1'b0;
      a_in = '0; b_in = '0; c_in = '0; d_in = '0; m_in = '0; valid_in = 1'b0;
      target_hash = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_found", match_found, 0);
      check("rst_search", searching, 0);
      check("rst_msg", match_msg, 0);

      // Basic hit: zero words match T_ZERO.
      en = 1'b1; start = 1'b1; target_hash = T_ZERO; tick(); start = 1'b0;
      check("start_search", searching, 1);
      drive(32'd0, 152'h1, 1'b1, 1'b1); tick();
      idle_inputs(); tick();
      check("hit_not_yet", match_found, 0);
      tick();
      check("hit_found", match_found, 1);
      check("hit_search_off", searching, 0);
      pop_check("hit_msg");
      ack = 1'b1; tick(); ack = 1'b0;
      check("ack_idle", match_found, 0);
      check("ack_keep_msg", match_msg, 152'h1);

      // Non-matching candidate.
      start = 1'b1; tick(); start = 1'b0;
      drive(32'd1, 152'h2, 1'b1, 1'b0); tick();
      idle_inputs(); tick(); tick();
      check("miss_search", searching, 1);
      check("miss_found", match_found, 0);
`ifdef HASH_COUNT_EN
      check("miss_count", hash_count, 1);
`endif

      // Back-to-back hits: first one wins.
      drive(32'd0, 152'hA, 1'b1, 1'b1); tick();
      drive(32'd0, 152'hB, 1'b1, 1'b0); tick();
      idle_inputs(); tick();
      check("b2b_found", match_found, 1);
      tick();
      pop_check("b2b_first");
      ack = 1'b1; tick(); ack = 1'b0;
      check("b2b_ack_idle", match_found, 0);
      check("b2b_retain", match_msg, 152'hA);

      // Hit sitting in stage 2 while en is low must wait.
      start = 1'b1; tick(); start = 1'b0;
      drive(32'd0, 152'hC, 1'b1, 1'b1); tick();
      idle_inputs(); tick();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_hold", match_found, 0);
      end
      en = 1'b1; tick();
      check("stall_found", match_found, 1);
      pop_check("stall_msg");

      // ack+start in FOUND: IDLE, target_reg keeps T_ZERO (shown by a hit judged before the next start lands).
      drive(32'd0, 152'h5, 1'b1, 1'b1);
      ack = 1'b1; start = 1'b1; target_hash = T_OTHER; tick();
      ack = 1'b0;
      check("ackstart_idle", match_found, 0);
      check("ackstart_nosearch", searching, 0);
      idle_inputs(); tick(); start = 1'b0;
      check("relaunch_search", searching, 1);
      tick();
      check("old_target_hit", match_found, 1);
      pop_check("old_target_msg");
      ack = 1'b1; tick(); ack = 1'b0;

      // Matching words with valid_in low are not candidates.
      start = 1'b1; target_hash = T_ZERO; tick(); start = 1'b0;
      drive(32'd0, 152'h6, 1'b0, 1'b0); tick(); tick(); tick();
      check("novalid_found", match_found, 0);

      // Reset one edge before the hit reaches stage 2 flushes it.
      drive(32'd0, 152'h7, 1'b1, 1'b0); tick();
      idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
      check("flush_found", match_found, 0);
      check("flush_msg", match_msg, 0);
      check("flush_idle", searching, 0);
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      check("flush_no_late", match_found, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
